axis_master_fifo: RTL and testbench
===================================

# axis_master_fifo

Parametrised AXI-Stream master output stage for the encoder datapath. It accepts samples from the encoder core through a valid/ready handshake and buffers up to DEPTH of them. It presents them on an AXI-Stream master port with a per-beat TLAST tag. It adds flush, full-throughput back-to-back transfers and a fill-level output, none of which the single-register output stage has.

## Interface
- DATA_W, default 81: sample/TDATA width.
- LAST_W, default 4: width of the LAST/TLAST side tag.
- DEPTH, default 4: buffer entries; power of two, at least 2.
- LVL_W, default $clog2(DEPTH+1): LEVEL width (derived, not overridden).

Ports:
- ACLK  in  1  single clock, rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- SAMPLE  in  DATA_W  sample from encoder core.
- LAST  in  LAST_W  tag travelling with SAMPLE.
- VALID_SAMPLE  in  1  SAMPLE/LAST valid.
- READY  out  LAST_W-independent 1  buffer can accept a sample this cycle.
- FLUSH  in  1  synchronous clear of all buffered beats.
- TVALID  out  1  AXI-S valid.
- TREADY  in  1  AXI-S ready from downstream.
- TDATA  out  DATA_W  AXI-S data.
- TLAST  out  LAST_W  tag of the current beat.
- LEVEL  out  LVL_W  number of buffered beats, 0..DEPTH.

## Operation
- Circular buffer: write pointer, read pointer (log2 DEPTH bits each, natural wrap) and count register (LVL_W bits).
- Push = VALID_SAMPLE && READY. Pop = TVALID && TREADY.
- READY = (count != DEPTH) and comes directly from the count register. It has no combinational path from TREADY, so a full buffer refuses a push even in a cycle where it pops.
- TVALID = (count != 0). TDATA/TLAST = entry at the read pointer when TVALID=1, all zeros when TVALID=0.
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and count is unchanged.
- FLUSH has priority over everything. On the next edge pointers and count go to 0, and the same-cycle push and pop are discarded. FLUSH does not clear the storage array, so stale data is never visible because TDATA is masked when empty.
- LEVEL = count.
- Ordering is strict FIFO. TLAST always stays paired with its own TDATA.
- ARESET while active, including mid-transfer: all buffered beats are lost, no partial beat is ever presented after release.

## Timing
- Reset values: READY=1, TVALID=0, TDATA=0, TLAST=0, LEVEL=0.
- Latency: a sample pushed at edge N is on TDATA with TVALID=1 from edge N (same cycle after the edge) when the buffer was empty. Otherwise it appears behind the older beats.
- While TVALID=1 && TREADY=0, TDATA/TLAST/TVALID hold stable until the pop. This is the AXI-S rule and has no exceptions except FLUSH/ARESET.
- Sustained throughput is one beat per cycle when TREADY=1 and VALID_SAMPLE=1 continuously and count < DEPTH.
- Full: READY=0. The first cycle after a pop from full has READY=1.
- Empty: a pop cannot occur because TVALID=0. Count never underflows or overflows.
- FLUSH asserted at edge N gives TVALID=0, READY=1, LEVEL=0 after edge N.

## Structure
- Shared package axis_pkg: default DATA_W/LAST_W/DEPTH constants, and a packed beat typedef {tlast, tdata} sized by the same parameters for other stream blocks.
- One sub-module, axis_beat_ram: a DEPTH x (DATA_W+LAST_W) register array with one write port and one asynchronous read port. Pointer, count, flush and handshake logic sit in the top level.
- No other hierarchy.

## Test plan
- Reset: ARESET=1 for 3 cycles with random inputs. After release READY=1, TVALID=0, TDATA=0, TLAST=0, LEVEL=0.
- Fill/backpressure: TREADY=0, push 0x1,0x2,0x3,0x4 (LAST=0,0,0,0xF). Result is LEVEL=4, READY=0, and a 5th VALID_SAMPLE is ignored. Then TREADY=1 drains 0x1..0x4 in order, with TLAST=0xF only on 0x4.
- Streaming: VALID_SAMPLE=1 and TREADY=1 for 100 cycles with an incrementing SAMPLE. Output is an identical sequence, LEVEL stays at 1, no bubbles.
- Stall stability: at LEVEL=2 toggle TREADY randomly. TDATA/TLAST are unchanged on every cycle with TVALID=1 && TREADY=0.
- Flush: at LEVEL=3, assert FLUSH together with VALID_SAMPLE=1 and TREADY=1. The next cycle has LEVEL=0, TVALID=0, READY=1, and the pushed sample is never emitted.
- Wrap/param: DEPTH=8, DATA_W=16. Run 1000 random push/pop cycles against a reference queue. Zero mismatches, and LEVEL always matches the queue size.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-Stream defaults and the packed beat type for stream blocks
package axis_pkg;
    localparam int AXIS_DATA_W = 81;
    localparam int AXIS_LAST_W = 4;
    localparam int AXIS_DEPTH  = 4;
    typedef struct packed {
        logic [AXIS_LAST_W-1:0] tlast;
        logic [AXIS_DATA_W-1:0] tdata;
    } axis_beat_t;
endpackage

// File: rtl/axis_beat_ram.sv
// axis_beat_ram: DEPTH x WIDTH register array, one write port, one asynchronous read port
// Ports: ACLK clock; we/waddr/wdata write port; raddr/rdata combinational read port.
module axis_beat_ram
    import axis_pkg::*;
#(
    parameter int WIDTH = AXIS_DATA_W + AXIS_LAST_W,
    parameter int DEPTH = AXIS_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             ACLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge ACLK)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/axis_master_fifo.sv
// axis_master_fifo: buffered AXI-Stream master output stage with flush and fill level
// Ports: ACLK/ARESET clock and async active-high reset; SAMPLE/LAST/VALID_SAMPLE/READY core-side push;
//        FLUSH synchronous clear; TVALID/TREADY/TDATA/TLAST AXI-S master; LEVEL buffered beat count.
module axis_master_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int LAST_W = AXIS_LAST_W,
    parameter int DEPTH  = AXIS_DEPTH,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] SAMPLE,
    input  logic [LAST_W-1:0] LAST,
    input  logic              VALID_SAMPLE,
    output logic              READY,
    input  logic              FLUSH,
    output logic              TVALID,
    input  logic              TREADY,
    output logic [DATA_W-1:0] TDATA,
    output logic [LAST_W-1:0] TLAST,
    output logic [LVL_W-1:0]  LEVEL
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic [LAST_W+DATA_W-1:0] rd_beat;
    logic push, pop;
    // READY comes from count only, so a full buffer refuses a push even while popping
    assign READY  = count != LVL_W'(DEPTH);
    assign TVALID = count != '0;
    assign push   = VALID_SAMPLE && READY;
    assign pop    = TVALID && TREADY;
    assign LEVEL  = count;
    // storage is never cleared; masking on TVALID hides stale entries after FLUSH/ARESET
    assign {TLAST, TDATA} = TVALID ? rd_beat : '0;
    axis_beat_ram #(.WIDTH(LAST_W + DATA_W), .DEPTH(DEPTH)) u_ram (
        .ACLK  (ACLK),
        .we    (push && !FLUSH),
        .waddr (wr_ptr),
        .wdata ({LAST, SAMPLE}),
        .raddr (rd_ptr),
        .rdata (rd_beat)
    );
    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + LVL_W'(push) - LVL_W'(pop);
        end
endmodule

// File: tb/tb_axis_master_fifo.sv
// tb_axis_master_fifo: directed and random scoreboard bench for the default and an 8-deep instance
module tb_axis_master_fifo;
    localparam int DW = 81, LW = 4, D = 4, DW8 = 16, D8 = 8;
    logic ACLK = 1'b0, ARESET = 1'b1;
    logic [DW-1:0] smp, td;
    logic [LW-1:0] lst, tl;
    logic vs, fl, tr, rdy, tv;
    logic [2:0] lvl;
    logic [DW8-1:0] b_smp, b_td;
    logic [LW-1:0] b_lst, b_tl;
    logic b_vs, b_fl, b_tr, b_rdy, b_tv;
    logic [3:0] b_lvl;
    typedef struct packed {logic [LW-1:0] l; logic [DW-1:0] d;} beat_t;
    typedef struct packed {logic [LW-1:0] l; logic [DW8-1:0] d;} beat8_t;
    beat_t q[$];
    beat8_t q8[$];
    int checks = 0, errors = 0;
    logic stalled;
    logic [LW+DW-1:0] held;
    always #5 ACLK = ~ACLK;
    axis_master_fifo dut (
        .ACLK(ACLK), .ARESET(ARESET), .SAMPLE(smp), .LAST(lst), .VALID_SAMPLE(vs), .READY(rdy),
        .FLUSH(fl), .TVALID(tv), .TREADY(tr), .TDATA(td), .TLAST(tl), .LEVEL(lvl)
    );
    axis_master_fifo #(.DATA_W(DW8), .DEPTH(D8)) dut8 (
        .ACLK(ACLK), .ARESET(ARESET), .SAMPLE(b_smp), .LAST(b_lst), .VALID_SAMPLE(b_vs), .READY(b_rdy),
        .FLUSH(b_fl), .TVALID(b_tv), .TREADY(b_tr), .TDATA(b_td), .TLAST(b_tl), .LEVEL(b_lvl)
    );
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        beat_t h = q.size() != 0 ? q[0] : '0;
        logic p = q.size() != 0 && tr;
        logic u = vs && q.size() != D;
        chk("level", 128'(lvl), 128'(q.size()));
        chk("ready", 128'(rdy), 128'(q.size() != D));
        chk("tvalid", 128'(tv), 128'(q.size() != 0));
        chk("tdata", 128'(td), 128'(h.d));
        chk("tlast", 128'(tl), 128'(h.l));
        if (fl) q.delete();
        else begin
            if (p) void'(q.pop_front());
            if (u) q.push_back({lst, smp});
        end
        @(posedge ACLK); #1;
    endtask
    task automatic cyc8();
        beat8_t h = q8.size() != 0 ? q8[0] : '0;
        logic p = q8.size() != 0 && b_tr;
        logic u = b_vs && q8.size() != D8;
        chk("b_level", 128'(b_lvl), 128'(q8.size()));
        chk("b_ready", 128'(b_rdy), 128'(q8.size() != D8));
        chk("b_tvalid", 128'(b_tv), 128'(q8.size() != 0));
        chk("b_tdata", 128'(b_td), 128'(h.d));
        chk("b_tlast", 128'(b_tl), 128'(h.l));
        if (b_fl) q8.delete();
        else begin
            if (p) void'(q8.pop_front());
            if (u) q8.push_back({b_lst, b_smp});
        end
        @(posedge ACLK); #1;
    endtask
    initial begin
        stalled = 1'b0;
        held = '0;
        repeat (3) begin
            smp = DW'({$urandom(), $urandom(), $urandom()});
            lst = LW'($urandom());
            {vs, fl, tr} = 3'($urandom());
            b_smp = DW8'($urandom());
            b_lst = LW'($urandom());
            {b_vs, b_fl, b_tr} = 3'($urandom());
            @(posedge ACLK);
        end
        #1;
        ARESET = 1'b0;
        {vs, fl, tr, b_vs, b_fl, b_tr} = '0;
        smp = '0; lst = '0; b_smp = '0; b_lst = '0;
        cyc();
        for (int i = 1; i <= 5; i++) begin
            vs = 1'b1;
            smp = DW'(i);
            lst = i == 4 ? 4'hF : 4'h0;
            cyc();
        end
        vs = 1'b0;
        cyc();
        tr = 1'b1;
        repeat (5) cyc();
        vs = 1'b1;
        for (int i = 0; i < 100; i++) begin
            smp = DW'(1000 + i);
            lst = LW'(i);
            cyc();
        end
        vs = 1'b0;
        repeat (2) cyc();
        tr = 1'b0;
        vs = 1'b1;
        for (int i = 0; i < 2; i++) begin
            smp = DW'(32'h500 + i);
            cyc();
        end
        for (int i = 0; i < 30; i++) begin
            tr = 1'($urandom());
            vs = tr;
            smp = DW'(32'h600 + i);
            lst = LW'(i);
            if (stalled) chk("stall_hold", 128'({tl, td}), 128'(held));
            stalled = tv && !tr;
            held = {tl, td};
            cyc();
        end
        vs = 1'b0;
        tr = 1'b1;
        repeat (4) cyc();
        tr = 1'b0;
        vs = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            smp = DW'(32'hA0 + i);
            lst = LW'(i);
            cyc();
        end
        fl = 1'b1;
        tr = 1'b1;
        smp = DW'(32'hDEAD);
        cyc();
        fl = 1'b0;
        vs = 1'b0;
        repeat (4) cyc();
        tr = 1'b0;
        vs = 1'b1;
        for (int i = 0; i < 2; i++) begin
            smp = DW'(32'hB0 + i);
            cyc();
        end
        vs = 1'b0;
        ARESET = 1'b1;
        #1;
        chk("areset_tvalid", 128'(tv), 128'(0));
        chk("areset_level", 128'(lvl), 128'(0));
        chk("areset_ready", 128'(rdy), 128'(1));
        q.delete();
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        tr = 1'b1;
        repeat (2) cyc();
        tr = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            b_vs = 1'($urandom());
            b_tr = 1'($urandom());
            b_fl = $urandom_range(0, 63) == 0;
            b_smp = DW8'($urandom());
            b_lst = LW'($urandom());
            cyc8();
        end
        {b_vs, b_fl} = '0;
        b_tr = 1'b1;
        repeat (10) cyc8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
